// File: rtl/asm_term_counter.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : asm_term_counter
// Brief    : Three-state ASM count controller (IDLE/ARM/COUNT). Counts
//            qualified x events by STEP from 0 up to a run-time terminal
//            value captured at start, then raises a sticky flag g and a
//            one-cycle done pulse. Supports synchronous abort and busy status.
// Revision : 1.0 - initial parametrised release
//==============================================================================
module asm_term_counter #(
  parameter int WIDTH = 4,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic             abort,
  input  logic             x,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] q,
  output logic             g,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state
);

  // Encoding is visible on the state port; 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARM   = 2'b01,
    ST_COUNT = 2'b10
  } state_t;

  // Increment reduced modulo 2^WIDTH so any STEP value wraps naturally.
  localparam logic [WIDTH-1:0] C_STEP = WIDTH'(STEP);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] r_term_q;
  logic [WIDTH-1:0] w_term_nxt;
  logic             r_g;
  logic             w_g_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_z;

  // Terminal match compares against the captured value, never the live input.
  assign w_z = (r_q == r_term_q);

  // Next-state, datapath and completion decode; everything holds by default.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_term_nxt  = r_term_q;
    w_g_nxt     = r_g;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Abort beats a simultaneous start request.
        if (s && !abort) begin
          w_q_nxt     = '0;
          w_g_nxt     = 1'b0;
          w_term_nxt  = term;
          w_state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (x) begin
          w_q_nxt     = r_q + C_STEP;
          w_state_nxt = ST_COUNT;
        end
      end
      ST_COUNT: begin
        // Abort outranks completion, which outranks a further increment.
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_z) begin
          w_g_nxt     = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (x) begin
          w_q_nxt     = r_q + C_STEP;
        end else begin
          w_state_nxt = ST_ARM;
        end
      end
      default: begin
        // Unused encoding: return to IDLE with q and g untouched.
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset acts immediately, without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_q      <= '0;
      r_term_q <= '0;
      r_g      <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_term_q <= w_term_nxt;
      r_g      <= w_g_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign q     = r_q;
  assign g     = r_g;
  assign done  = r_done;
  assign busy  = (r_state != ST_IDLE);
  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_asm_term_counter.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_asm_term_counter
// Brief    : Table-driven self-checking bench for asm_term_counter, using a
//            4-bit/STEP=1 instance and an 8-bit/STEP=4 instance.
// Revision : 1.0 - initial release
//==============================================================================
module tb_asm_term_counter;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] ARM   = 2'b01;
  localparam logic [1:0] COUNT = 2'b10;

  logic       clk = 1'b0;
  logic       rst;
  logic       s4, abort4, x4;
  logic [3:0] term4, q4;
  logic       g4, done4, busy4;
  logic [1:0] state4;
  logic       s8, abort8, x8;
  logic [7:0] term8, q8;
  logic       g8, done8, busy8;
  logic [1:0] state8;

  int checks = 0;
  int errors = 0;

  asm_term_counter #(.WIDTH(4), .STEP(1)) dut4 (
    .clk(clk), .rst(rst), .s(s4), .abort(abort4), .x(x4), .term(term4),
    .q(q4), .g(g4), .done(done4), .busy(busy4), .state(state4)
  );

  asm_term_counter #(.WIDTH(8), .STEP(4)) dut8 (
    .clk(clk), .rst(rst), .s(s8), .abort(abort8), .x(x8), .term(term8),
    .q(q8), .g(g8), .done(done8), .busy(busy8), .state(state8)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected after the next rising edge.
  typedef struct {
    bit         wide;
    int         tag;
    int         idx;
    bit         s, abort, x;
    logic [7:0] term;
    logic [1:0] state;
    logic [7:0] q;
    bit         g, done, busy;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(input bit wide, input int tag, input bit s, input bit a,
                              input bit x, input logic [7:0] term, input logic [1:0] st,
                              input logic [7:0] q, input bit g, input bit d, input bit b);
    vec_t v;
    v.wide = wide; v.tag = tag; v.idx = 0;
    v.s = s; v.abort = a; v.x = x; v.term = term;
    v.state = st; v.q = q; v.g = g; v.done = d; v.busy = b;
    return v;
  endfunction

  task automatic add(input vec_t v);
    v.idx = vecs.size();
    vecs.push_back(v);
  endtask

  task automatic check_out(input vec_t e);
    logic [1:0] a_st;
    logic [7:0] a_q;
    logic       a_g, a_d, a_b;
    if (e.wide) begin
      a_st = state8; a_q = q8; a_g = g8; a_d = done8; a_b = busy8;
    end else begin
      a_st = state4; a_q = {4'b0000, q4}; a_g = g4; a_d = done4; a_b = busy4;
    end
    checks++;
    if (a_st !== e.state || a_q !== e.q || a_g !== e.g || a_d !== e.done || a_b !== e.busy) begin
      errors++;
      $display("FAIL seq%0d vec%0d: got state=%b q=%0d g=%b done=%b busy=%b, expected state=%b q=%0d g=%b done=%b busy=%b",
               e.tag, e.idx, a_st, a_q, a_g, a_d, a_b, e.state, e.q, e.g, e.done, e.busy);
    end
  endtask

  // Drive on the falling edge, queue the expectation, compare after the rising edge.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    s4     = v.wide ? 1'b0 : v.s;
    abort4 = v.wide ? 1'b0 : v.abort;
    x4     = v.wide ? 1'b0 : v.x;
    term4  = v.term[3:0];
    s8     = v.wide ? v.s : 1'b0;
    abort8 = v.wide ? v.abort : 1'b0;
    x8     = v.wide ? v.x : 1'b0;
    term8  = v.term;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_out(e);
  endtask

  task automatic check_rst(input string name);
    checks++;
    if (q4 !== 4'd0 || g4 !== 1'b0 || done4 !== 1'b0 || busy4 !== 1'b0 || state4 !== IDLE ||
        q8 !== 8'd0 || g8 !== 1'b0 || done8 !== 1'b0 || busy8 !== 1'b0 || state8 !== IDLE) begin
      errors++;
      $display("FAIL %s: got q4=%0d g4=%b done4=%b busy4=%b state4=%b q8=%0d g8=%b state8=%b, expected all zero",
               name, q4, g4, done4, busy4, state4, q8, g8, state8);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    s4 = 0; abort4 = 0; x4 = 0; term4 = '0;
    s8 = 0; abort8 = 0; x8 = 0; term8 = '0;

    // Seq 1: term=15, x held high; live term changed to 5 mid-run (must be ignored).
    add(mk(0, 1, 1, 0, 1, 8'd15, ARM, 8'd0, 0, 0, 1));
    for (int i = 1; i <= 15; i++) add(mk(0, 1, 0, 0, 1, 8'd5, COUNT, 8'(i), 0, 0, 1));
    add(mk(0, 1, 0, 0, 1, 8'd5, IDLE, 8'd15, 1, 1, 0));
    add(mk(0, 1, 0, 0, 1, 8'd5, IDLE, 8'd15, 1, 0, 0));

    // Seq 2: term=3, x alternating from ARM; start clears the previous sticky g.
    add(mk(0, 2, 1, 0, 0, 8'd3, ARM,   8'd0, 0, 0, 1));
    add(mk(0, 2, 0, 0, 1, 8'd3, COUNT, 8'd1, 0, 0, 1));
    add(mk(0, 2, 0, 0, 0, 8'd3, ARM,   8'd1, 0, 0, 1));
    add(mk(0, 2, 0, 0, 1, 8'd3, COUNT, 8'd2, 0, 0, 1));
    add(mk(0, 2, 0, 0, 0, 8'd3, ARM,   8'd2, 0, 0, 1));
    add(mk(0, 2, 0, 0, 1, 8'd3, COUNT, 8'd3, 0, 0, 1));
    add(mk(0, 2, 0, 0, 0, 8'd3, IDLE,  8'd3, 1, 1, 0));
    add(mk(0, 2, 0, 0, 0, 8'd3, IDLE,  8'd3, 1, 0, 0));

    // Seq 3: abort at q=7 (term=12), s+abort in IDLE, restart, abort from ARM.
    add(mk(0, 3, 1, 0, 1, 8'd12, ARM, 8'd0, 0, 0, 1));
    for (int i = 1; i <= 7; i++) add(mk(0, 3, 0, 0, 1, 8'd12, COUNT, 8'(i), 0, 0, 1));
    add(mk(0, 3, 0, 1, 1, 8'd12, IDLE, 8'd7, 0, 0, 0));
    add(mk(0, 3, 0, 0, 1, 8'd12, IDLE, 8'd7, 0, 0, 0));
    add(mk(0, 3, 1, 1, 0, 8'd12, IDLE, 8'd7, 0, 0, 0));
    add(mk(0, 3, 1, 0, 0, 8'd12, ARM,  8'd0, 0, 0, 1));
    add(mk(0, 3, 0, 1, 1, 8'd12, IDLE, 8'd0, 0, 0, 0));

    // Seq 4: term=0 completes only after wrap; s mid-run and live term=7 ignored.
    add(mk(0, 4, 1, 0, 1, 8'd0, ARM, 8'd0, 0, 0, 1));
    for (int i = 1; i <= 15; i++) add(mk(0, 4, (i == 8), 0, 1, 8'd7, COUNT, 8'(i), 0, 0, 1));
    add(mk(0, 4, 0, 0, 1, 8'd7, COUNT, 8'd0, 0, 0, 1));
    add(mk(0, 4, 0, 0, 1, 8'd7, IDLE,  8'd0, 1, 1, 0));
    add(mk(0, 4, 0, 0, 0, 8'd7, IDLE,  8'd0, 1, 0, 0));

    // Seq 5: WIDTH=8, STEP=4, term=6 is unreachable; runs through wrap until abort.
    add(mk(1, 5, 1, 0, 1, 8'd6, ARM, 8'd0, 0, 0, 1));
    for (int i = 1; i <= 70; i++) add(mk(1, 5, 0, 0, 1, 8'd6, COUNT, 8'((4 * i) % 256), 0, 0, 1));
    add(mk(1, 5, 0, 1, 1, 8'd6, IDLE, 8'd24, 0, 0, 0));
    add(mk(1, 5, 0, 0, 1, 8'd6, IDLE, 8'd24, 0, 0, 0));

    // Seq 6: bring the 4-bit counter to q=5 in COUNT ahead of the async reset.
    add(mk(0, 6, 1, 0, 1, 8'd9, ARM, 8'd0, 0, 0, 1));
    for (int i = 1; i <= 5; i++) add(mk(0, 6, 0, 0, 1, 8'd9, COUNT, 8'(i), 0, 0, 1));

    repeat (2) @(posedge clk);
    #1;
    check_rst("reset_state");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Reset must clear outputs before any further clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_rst("async_rst_mid_count");
    @(posedge clk);
    #1;
    check_rst("rst_held");
    @(negedge clk);
    rst = 1'b0;

    // Seq 7: normal operation after release, short term=2 run.
    step(mk(0, 7, 1, 0, 1, 8'd2, ARM,   8'd0, 0, 0, 1));
    step(mk(0, 7, 0, 0, 1, 8'd2, COUNT, 8'd1, 0, 0, 1));
    step(mk(0, 7, 0, 0, 1, 8'd2, COUNT, 8'd2, 0, 0, 1));
    step(mk(0, 7, 0, 0, 1, 8'd2, IDLE,  8'd2, 1, 1, 0));
    step(mk(0, 7, 0, 0, 0, 8'd2, IDLE,  8'd2, 1, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
